ber_checker: RTL and testbench

- Receive-side bit-error-rate stage; sits directly downstream of the downsampler that follows the pulse-shaping filter.
- Consumes one symbol-rate sample per T strobe (one `clock` cycle in every OV_SAMP cycles) and slices it to a bit.
- Aligns the sliced bit stream against the local PRBS reference bit by searching the channel delay.
- Once aligned, accumulates bit and error counts for readout on LEDs or a debug bus.

---
 rtl/ber_checker_pkg.sv | 13 +
 rtl/ber_ref_delay_line.sv | 27 ++
 rtl/ber_checker.sv | 81 ++++++++
 tb/tb_ber_checker.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/ber_checker_pkg.sv
// ber_checker_pkg: state encoding, default widths and the PRBS9 generator shared by the BER checker, transmitter and bench
package ber_checker_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, LOCKED = 2'd2} state_t;
  localparam int NB_INPUT_DEF = 8;
  localparam int NB_DELAY_DEF = 9;
  localparam int NB_CNT_DEF = 64;
  localparam logic [8:0] PRBS9_POLY = 9'h110;
  localparam logic [8:0] PRBS9_SEED = 9'h1AA;
  // x^9 + x^5 + 1 Fibonacci step; the transmitted bit is state[8]
  function automatic logic [8:0] prbs9_next(input logic [8:0] s);
    return {s[7:0], ^(s & PRBS9_POLY)};
  endfunction
endpackage

// File: rtl/ber_ref_delay_line.sv
// ber_ref_delay_line: reference-bit shift register with a combinational tap selected by the candidate delay
module ber_ref_delay_line
  import ber_checker_pkg::*;
#(
  parameter int DEPTH    = 511,
  parameter int NB_DELAY = NB_DELAY_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_clear,
  input  logic                i_shift,
  input  logic                i_bit,
  input  logic [NB_DELAY-1:0] i_delay,
  output logic                o_cand
);
  logic [DEPTH-1:0] sr;
  logic [NB_DELAY-1:0] idx;
  always_ff @(posedge clock or negedge reset)
    if (!reset) sr <= '0;
    else if (i_clear) sr <= '0;
    else if (i_shift) sr <= {sr[DEPTH-2:0], i_bit};
  // delay 0 compares against the bit arriving on this strobe
  always_comb begin
    idx = i_delay - NB_DELAY'(1);
    o_cand = (i_delay == '0) ? i_bit : sr[idx];
  end
endmodule

// File: rtl/ber_checker.sv
// ber_checker: slices rx samples, searches the channel delay against the PRBS reference, then counts bits and errors
module ber_checker
  import ber_checker_pkg::*;
#(
  parameter int NB_INPUT  = NB_INPUT_DEF,
  parameter int NB_DELAY  = NB_DELAY_DEF,
  parameter int MAX_DELAY = 511,
  parameter int SYNC_LEN  = 511,
  parameter int ERR_THR   = 0,
  parameter int NB_CNT    = NB_CNT_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_enable,
  input  logic                       i_run,
  input  logic                       i_ref_bit,
  input  logic signed [NB_INPUT-1:0] i_rx_sample,
  output logic                       o_locked,
  output logic        [NB_DELAY-1:0] o_delay,
  output logic        [NB_CNT-1:0]   o_bit_count,
  output logic        [NB_CNT-1:0]   o_err_count
);
  localparam int NB_WIN = $clog2(SYNC_LEN + 1);
  state_t state;
  logic run_q, cand, err, start;
  logic [NB_WIN-1:0] win_cnt, win_err;
  logic [NB_WIN:0] win_tot;
  assign start = (state == IDLE) && i_run && !run_q;
  assign err = i_rx_sample[NB_INPUT-1] ^ cand;
  assign win_tot = {1'b0, win_err} + {{NB_WIN{1'b0}}, err};
  ber_ref_delay_line #(.DEPTH(MAX_DELAY), .NB_DELAY(NB_DELAY)) u_dl (
    .clock  (clock),
    .reset  (reset),
    .i_clear(start),
    .i_shift(i_enable && i_run && state != IDLE),
    .i_bit  (i_ref_bit),
    .i_delay(o_delay),
    .o_cand (cand)
  );
  // run_q resets high so a level already high at reset release is not taken as a start
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      run_q <= 1'b1;
      win_cnt <= '0;
      win_err <= '0;
      o_locked <= 1'b0;
      o_delay <= '0;
      o_bit_count <= '0;
      o_err_count <= '0;
    end else begin
      run_q <= i_run;
      if (!i_run) state <= IDLE;
      else if (start) begin
        state <= SEARCH;
        win_cnt <= '0;
        win_err <= '0;
        o_locked <= 1'b0;
        o_delay <= '0;
        o_bit_count <= '0;
        o_err_count <= '0;
      end else if (i_enable && state == SEARCH) begin
        if (win_cnt == NB_WIN'(SYNC_LEN - 1)) begin
          win_cnt <= '0;
          win_err <= '0;
          if (win_tot <= (NB_WIN + 1)'(ERR_THR)) begin
            state <= LOCKED;
            o_locked <= 1'b1;
            o_bit_count <= '0;
            o_err_count <= '0;
          end else o_delay <= (o_delay == NB_DELAY'(MAX_DELAY)) ? '0 : o_delay + NB_DELAY'(1);
        end else begin
          win_cnt <= win_cnt + NB_WIN'(1);
          win_err <= win_tot[NB_WIN-1:0];
        end
      end else if (i_enable && state == LOCKED) begin
        if (~&o_bit_count) o_bit_count <= o_bit_count + NB_CNT'(1);
        if (err && ~&o_err_count) o_err_count <= o_err_count + NB_CNT'(1);
      end
    end
endmodule

// File: tb/tb_ber_checker.sv
// tb_ber_checker: directed tests of delay search, error counting, wrap, saturation, async reset and run priority
module tb_ber_checker;
  import ber_checker_pkg::*;
  localparam int SL = 16;
  logic clock = 0, reset = 0, i_enable = 0, i_run = 0, i_ref_bit = 0;
  logic signed [7:0] i_rx_sample = 0;
  logic o_locked, s_locked;
  logic [8:0] o_delay, s_delay;
  logic [63:0] o_bit_count, o_err_count;
  logic [7:0] s_bit_count, s_err_count;
  int total = 0, bad = 0;
  logic [8:0] prbs = PRBS9_SEED;
  logic [1023:0] hist = '0;

  ber_checker #(.SYNC_LEN(SL)) dut (
    .clock(clock), .reset(reset), .i_enable(i_enable), .i_run(i_run), .i_ref_bit(i_ref_bit),
    .i_rx_sample(i_rx_sample), .o_locked(o_locked), .o_delay(o_delay),
    .o_bit_count(o_bit_count), .o_err_count(o_err_count));

  ber_checker #(.SYNC_LEN(SL), .NB_CNT(8)) dut_sat (
    .clock(clock), .reset(reset), .i_enable(i_enable), .i_run(i_run), .i_ref_bit(i_ref_bit),
    .i_rx_sample(i_rx_sample), .o_locked(s_locked), .o_delay(s_delay),
    .o_bit_count(s_bit_count), .o_err_count(s_err_count));

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // channel model: rx is the reference delayed d strobes, optionally sign-flipped
  task automatic chan(input int d, input bit flip, input int gap, input bit run = 1'b1);
    logic r, x;
    r = prbs[8];
    x = ((d == 0) ? r : hist[d-1]) ^ flip;
    hist = {hist[1022:0], r};
    prbs = prbs9_next(prbs);
    i_enable = 1'b1;
    i_ref_bit = r;
    i_rx_sample = x ? -8'sd64 : 8'sd64;
    i_run = run;
    tick;
    i_enable = 1'b0;
    repeat (gap - 1) tick;
  endtask

  task automatic start_run;
    i_run = 1'b0;
    tick;
    tick;
    hist = '0;
    prbs = PRBS9_SEED;
    i_run = 1'b1;
    tick;
    tick;
  endtask

  task automatic test_reset;
    #2;
    total++; if (o_locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%0d want=0", o_locked); end
    total++; if (o_delay !== 9'd0) begin bad++; $display("FAIL reset_delay got=%0d want=0", o_delay); end
    total++; if (o_bit_count !== 64'd0) begin bad++; $display("FAIL reset_bits got=%0d want=0", o_bit_count); end
    total++; if (o_err_count !== 64'd0) begin bad++; $display("FAIL reset_errs got=%0d want=0", o_err_count); end
    tick;
    reset = 1'b1;
    tick;
  endtask

  task automatic test_delay37;
    start_run;
    for (int k = 1; k < 38 * SL; k++) chan(37, 1'b0, 4);
    total++; if (o_locked !== 1'b0) begin bad++; $display("FAIL d37_prelock got=%0d want=0", o_locked); end
    total++; if (o_delay !== 9'd37) begin bad++; $display("FAIL d37_prelock_delay got=%0d want=37", o_delay); end
    chan(37, 1'b0, 4);
    total++; if (o_locked !== 1'b1) begin bad++; $display("FAIL d37_lock got=%0d want=1", o_locked); end
    total++; if (o_delay !== 9'd37) begin bad++; $display("FAIL d37_delay got=%0d want=37", o_delay); end
    total++; if (o_bit_count !== 64'd0) begin bad++; $display("FAIL d37_bits got=%0d want=0", o_bit_count); end
  endtask

  task automatic test_err_count;
    for (int k = 1; k <= 10000; k++) chan(37, (k % 100) == 0, 2);
    total++; if (o_bit_count !== 64'd10000) begin bad++; $display("FAIL errcnt_bits got=%0d want=10000", o_bit_count); end
    total++; if (o_err_count !== 64'd100) begin bad++; $display("FAIL errcnt_errs got=%0d want=100", o_err_count); end
    total++; if (o_locked !== 1'b1) begin bad++; $display("FAIL errcnt_locked got=%0d want=1", o_locked); end
  endtask

  task automatic test_run_priority;
    chan(37, 1'b1, 2, 1'b0);
    repeat (3) chan(37, 1'b1, 2, 1'b0);
    total++; if (o_bit_count !== 64'd10000) begin bad++; $display("FAIL prio_bits got=%0d want=10000", o_bit_count); end
    total++; if (o_err_count !== 64'd100) begin bad++; $display("FAIL prio_errs got=%0d want=100", o_err_count); end
    start_run;
    total++; if (o_bit_count !== 64'd0) begin bad++; $display("FAIL prio_clr_bits got=%0d want=0", o_bit_count); end
    total++; if (o_err_count !== 64'd0) begin bad++; $display("FAIL prio_clr_errs got=%0d want=0", o_err_count); end
    total++; if (o_locked !== 1'b0) begin bad++; $display("FAIL prio_clr_locked got=%0d want=0", o_locked); end
    total++; if (o_delay !== 9'd0) begin bad++; $display("FAIL prio_clr_delay got=%0d want=0", o_delay); end
    repeat (SL) chan(37, 1'b0, 2);
    total++; if (o_delay !== 9'd1) begin bad++; $display("FAIL prio_search got=%0d want=1", o_delay); end
  endtask

  task automatic test_wrap;
    start_run;
    for (int w = 0; w < 512; w++) begin
      repeat (SL) chan(0, 1'b1, 2);
      total++; if (o_delay !== 9'((w + 1) % 512) || o_locked !== 1'b0) begin
        bad++; $display("FAIL wrap_w%0d got delay=%0d locked=%0d want delay=%0d locked=0", w, o_delay, o_locked, (w + 1) % 512);
      end
    end
  endtask

  task automatic test_saturation;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    start_run;
    repeat (SL) chan(0, 1'b0, 2);
    total++; if (s_locked !== 1'b1) begin bad++; $display("FAIL sat_lock got=%0d want=1", s_locked); end
    repeat (300) chan(0, 1'b1, 2);
    total++; if (s_bit_count !== 8'd255) begin bad++; $display("FAIL sat_bits got=%0d want=255", s_bit_count); end
    total++; if (s_err_count !== 8'd255) begin bad++; $display("FAIL sat_errs got=%0d want=255", s_err_count); end
    total++; if (o_err_count !== 64'd300) begin bad++; $display("FAIL sat_wide_errs got=%0d want=300", o_err_count); end
    repeat (5) chan(0, 1'b1, 2);
    total++; if (s_bit_count !== 8'd255 || s_err_count !== 8'd255) begin
      bad++; $display("FAIL sat_hold got bits=%0d errs=%0d want 255/255", s_bit_count, s_err_count);
    end
  endtask

  task automatic test_async_reset;
    start_run;
    repeat (5 * SL) chan(0, 1'b1, 2);
    total++; if (o_delay !== 9'd5) begin bad++; $display("FAIL areset_pre got=%0d want=5", o_delay); end
    reset = 1'b0;
    #2;
    total++; if (o_delay !== 9'd0 || o_locked !== 1'b0 || o_bit_count !== 64'd0 || o_err_count !== 64'd0) begin
      bad++; $display("FAIL areset_now got delay=%0d locked=%0d bits=%0d errs=%0d want all 0", o_delay, o_locked, o_bit_count, o_err_count);
    end
    tick;
    reset = 1'b1;
    repeat (3 * SL) chan(0, 1'b1, 2);
    total++; if (o_delay !== 9'd0) begin bad++; $display("FAIL areset_idle got=%0d want=0", o_delay); end
    start_run;
    repeat (SL) chan(0, 1'b1, 2);
    total++; if (o_delay !== 9'd1) begin bad++; $display("FAIL areset_restart got=%0d want=1", o_delay); end
  endtask

  initial begin
    test_reset;
    test_delay37;
    test_err_count;
    test_run_priority;
    test_wrap;
    test_saturation;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
